// File: rtl/chunk_row_burst_pkg.sv
// ============================================================================
// Module : chunk_row_burst_pkg
// Brief  : Shared configuration and FSM state encoding for chunk_row_burst.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

package chunk_row_burst_pkg;

  localparam int GLOBAL_ADDR_BW = 32;
  localparam int VSIZE          = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/chunk_row_burst_if.sv
// ============================================================================
// Module : chunk_row_burst_if
// Brief  : Row-descriptor input stream and line-beat output stream bundle.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

interface chunk_row_burst_if #(
  parameter int GBW   = 32,
  parameter int VSIZE = 32
);
  localparam int V_BW = $clog2(VSIZE);

  logic            row_rdy;
  logic            row_ack;
  logic [GBW-1:0]  i_row_linear;
  logic [GBW-1:0]  i_row_last;
  logic            i_row_islast;
  logic [V_BW-1:0] i_row_pad;
  logic            i_row_valid;

  logic            line_rdy;
  logic            line_ack;
  logic [GBW-1:0]  o_line_addr;
  logic            o_line_first;
  logic            o_line_last;
  logic            o_line_clast;
  logic [V_BW-1:0] o_line_sofs;
  logic [V_BW-1:0] o_line_eofs;
  logic [V_BW-1:0] o_line_pad;
  logic            o_line_fill;

  modport slave (
    input  row_rdy, i_row_linear, i_row_last, i_row_islast, i_row_pad, i_row_valid,
    output row_ack,
    output line_rdy, o_line_addr, o_line_first, o_line_last, o_line_clast,
    output o_line_sofs, o_line_eofs, o_line_pad, o_line_fill,
    input  line_ack
  );

  modport master (
    output row_rdy, i_row_linear, i_row_last, i_row_islast, i_row_pad, i_row_valid,
    input  row_ack,
    input  line_rdy, o_line_addr, o_line_first, o_line_last, o_line_clast,
    input  o_line_sofs, o_line_eofs, o_line_pad, o_line_fill,
    output line_ack
  );

endinterface

`default_nettype wire

// File: rtl/chunk_row_beat_calc.sv
// ============================================================================
// Module : chunk_row_beat_calc
// Brief  : Combinational first-beat geometry of a row: line bounds and offsets.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module chunk_row_beat_calc #(
  parameter int GBW   = 32,
  parameter int VSIZE = 32,
  parameter int V_BW  = $clog2(VSIZE)
) (
  input  logic [GBW-1:0]  i_linear,
  input  logic [GBW-1:0]  i_row_last,
  output logic [GBW-1:0]  o_cur,
  output logic [GBW-1:0]  o_stop,
  output logic [V_BW-1:0] o_sofs,
  output logic [V_BW-1:0] o_end_ofs,
  output logic [V_BW-1:0] o_eofs,
  output logic            o_last
);

  localparam logic [GBW-1:0] c_line_mask = ~(GBW'(VSIZE) - GBW'(1));

  logic [GBW-1:0] w_end;

  // End address wraps modulo 2^GBW; the looper bounds rows so this is benign.
  always_comb begin
    w_end     = i_linear + i_row_last;
    o_cur     = i_linear & c_line_mask;
    o_stop    = w_end & c_line_mask;
    o_sofs    = i_linear[V_BW-1:0];
    o_end_ofs = w_end[V_BW-1:0];
    o_last    = (o_cur == o_stop);
    o_eofs    = o_last ? o_end_ofs : '1;
  end

endmodule

`default_nettype wire

// File: rtl/chunk_row_burst.sv
// ============================================================================
// Module : chunk_row_burst
// Brief  : Expands accepted row descriptors into VSIZE-aligned line beats.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module chunk_row_burst #(
  parameter int GBW   = chunk_row_burst_pkg::GLOBAL_ADDR_BW,
  parameter int VSIZE = chunk_row_burst_pkg::VSIZE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  chunk_row_burst_if.slave  bus
);
  import chunk_row_burst_pkg::*;

  localparam int             V_BW    = $clog2(VSIZE);
  localparam logic [GBW-1:0] c_vstep = GBW'(VSIZE);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_row_ack;
  logic            w_load;
  logic            w_adv;

  logic            r_line_rdy;
  logic [GBW-1:0]  r_addr;
  logic            r_first;
  logic            r_last;
  logic            r_clast;
  logic [V_BW-1:0] r_sofs;
  logic [V_BW-1:0] r_eofs;
  logic [V_BW-1:0] r_pad;
  logic            r_fill;
  logic [GBW-1:0]  r_stop;
  logic [V_BW-1:0] r_end_ofs;
  logic            r_islast;

  logic [GBW-1:0]  w_cur;
  logic [GBW-1:0]  w_stop;
  logic [V_BW-1:0] w_sofs;
  logic [V_BW-1:0] w_end_ofs;
  logic [V_BW-1:0] w_eofs;
  logic            w_first_last;
  logic [GBW-1:0]  w_addr_inc;
  logic            w_inc_last;

  chunk_row_beat_calc #(
    .GBW   (GBW),
    .VSIZE (VSIZE),
    .V_BW  (V_BW)
  ) u_beat_calc (
    .i_linear   (bus.i_row_linear),
    .i_row_last (bus.i_row_last),
    .o_cur      (w_cur),
    .o_stop     (w_stop),
    .o_sofs     (w_sofs),
    .o_end_ofs  (w_end_ofs),
    .o_eofs     (w_eofs),
    .o_last     (w_first_last)
  );

  assign w_addr_inc = r_addr + c_vstep;
  assign w_inc_last = (w_addr_inc == r_stop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The last beat's acceptance doubles as the next row's acceptance slot.
  always_comb begin
    w_state_nxt = r_state;
    w_row_ack   = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_row_ack = 1'b1;
        if (bus.row_rdy) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.line_ack) begin
          if (r_last) begin
            w_row_ack = 1'b1;
            if (bus.row_rdy) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_line_rdy <= 1'b0;
      r_addr     <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_clast    <= 1'b0;
      r_sofs     <= '0;
      r_eofs     <= '0;
      r_pad      <= '0;
      r_fill     <= 1'b0;
      r_stop     <= '0;
      r_end_ofs  <= '0;
      r_islast   <= 1'b0;
    end else if (w_load) begin
      r_line_rdy <= 1'b1;
      r_addr     <= w_cur;
      r_first    <= 1'b1;
      r_last     <= w_first_last;
      r_clast    <= w_first_last & bus.i_row_islast;
      r_sofs     <= w_sofs;
      r_eofs     <= w_eofs;
      r_pad      <= bus.i_row_pad;
      r_fill     <= ~bus.i_row_valid;
      r_stop     <= w_stop;
      r_end_ofs  <= w_end_ofs;
      r_islast   <= bus.i_row_islast;
    end else if (w_adv) begin
      r_addr     <= w_addr_inc;
      r_first    <= 1'b0;
      r_last     <= w_inc_last;
      r_clast    <= w_inc_last & r_islast;
      r_sofs     <= '0;
      r_eofs     <= w_inc_last ? r_end_ofs : '1;
      r_pad      <= '0;
    end else if ((r_state == ST_RUN) && bus.line_ack && r_last) begin
      r_line_rdy <= 1'b0;
    end
  end

  assign bus.row_ack      = w_row_ack;
  assign bus.line_rdy     = r_line_rdy;
  assign bus.o_line_addr  = r_addr;
  assign bus.o_line_first = r_first;
  assign bus.o_line_last  = r_last;
  assign bus.o_line_clast = r_clast;
  assign bus.o_line_sofs  = r_sofs;
  assign bus.o_line_eofs  = r_eofs;
  assign bus.o_line_pad   = r_pad;
  assign bus.o_line_fill  = r_fill;

endmodule

`default_nettype wire
